// File: rtl/conv_scheduler.sv
// Address/control sequencer for the 5x5 valid-convolution MAC datapath.
// Optional cycle_count port and counter are built only when CONV_PERF_CNT_EN is defined.
module conv_scheduler #(
    parameter int DATA_X   = 28,
    parameter int DATA_Y   = 28,
    parameter int WEIGHT_X = 5,
    parameter int WEIGHT_Y = 5,
    parameter int ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              conv_enable,
    output logic              busy,
    output logic              tap_valid,
    input  logic              tap_ready,
    output logic [ADDR_W-1:0] data_addr,
    output logic [4:0]        weight_addr,
    output logic              tap_first,
    output logic              tap_last,
    output logic              result_wr,
    output logic [4:0]        out_row,
    output logic [4:0]        out_col,
    output logic              conv_done
`ifdef CONV_PERF_CNT_EN
    ,
    output logic [31:0]       cycle_count
`endif
);

    localparam int CONV_X = DATA_X - WEIGHT_X + 1;
    localparam int CONV_Y = DATA_Y - WEIGHT_Y + 1;
    localparam int KR_W   = (WEIGHT_X > 1) ? $clog2(WEIGHT_X) : 1;
    localparam int KC_W   = (WEIGHT_Y > 1) ? $clog2(WEIGHT_Y) : 1;
    localparam int OR_W   = (CONV_X > 1) ? $clog2(CONV_X) : 1;
    localparam int OC_W   = (CONV_Y > 1) ? $clog2(CONV_Y) : 1;

    localparam logic [KR_W-1:0] KR_LAST = KR_W'(WEIGHT_X - 1);
    localparam logic [KC_W-1:0] KC_LAST = KC_W'(WEIGHT_Y - 1);
    localparam logic [OR_W-1:0] OR_LAST = OR_W'(CONV_X - 1);
    localparam logic [OC_W-1:0] OC_LAST = OC_W'(CONV_Y - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_next;

    logic [KR_W-1:0] kr, kr_n;
    logic [KC_W-1:0] kc, kc_n;
    logic [OR_W-1:0] orow, orow_n;
    logic [OC_W-1:0] ocol, ocol_n;

    logic              tap_xfer;
    logic              window_end;
    logic              final_tap;
    logic              start;

    logic              busy_n;
    logic              tap_valid_n;
    logic [ADDR_W-1:0] data_addr_n;
    logic [4:0]        weight_addr_n;
    logic              tap_first_n;
    logic              tap_last_n;
    logic              result_wr_n;
    logic [4:0]        out_row_n;
    logic [4:0]        out_col_n;
    logic              conv_done_n;

    assign tap_xfer   = tap_valid && tap_ready;
    assign window_end = (kr == KR_LAST) && (kc == KC_LAST);
    assign final_tap  = window_end && (orow == OR_LAST) && (ocol == OC_LAST);
    assign start      = (state == IDLE) && conv_enable;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (conv_enable) state_next = RUN;
            RUN:     if (tap_xfer && final_tap) state_next = DRAIN;
            DRAIN:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Window walk: kc innermost, then kr, then output column, then output row.
    // Every counter wraps to zero after the final tap, leaving IDLE ready for the next run.
    always_comb begin
        kr_n   = kr;
        kc_n   = kc;
        orow_n = orow;
        ocol_n = ocol;
        if (start) begin
            kr_n   = '0;
            kc_n   = '0;
            orow_n = '0;
            ocol_n = '0;
        end else if ((state == RUN) && tap_xfer) begin
            if (kc == KC_LAST) begin
                kc_n = '0;
                if (kr == KR_LAST) begin
                    kr_n = '0;
                    if (ocol == OC_LAST) begin
                        ocol_n = '0;
                        orow_n = (orow == OR_LAST) ? '0 : orow + OR_W'(1);
                    end else begin
                        ocol_n = ocol + OC_W'(1);
                    end
                end else begin
                    kr_n = kr + KR_W'(1);
                end
            end else begin
                kc_n = kc + KC_W'(1);
            end
        end
    end

    // Next values of the registered outputs; tap fields are derived from the next counters,
    // so a stalled tap recomputes identical values and the outputs hold.
    always_comb begin
        tap_valid_n   = (state_next == RUN);
        busy_n        = (state_next == RUN) || (state_next == DRAIN);
        conv_done_n   = (state_next == DONE);
        result_wr_n   = (state == RUN) && tap_xfer && window_end;
        out_row_n     = out_row;
        out_col_n     = out_col;
        data_addr_n   = '0;
        weight_addr_n = '0;
        tap_first_n   = 1'b0;
        tap_last_n    = 1'b0;
        if (result_wr_n) begin
            out_row_n = 5'(orow);
            out_col_n = 5'(ocol);
        end
        if (tap_valid_n) begin
            data_addr_n   = (ADDR_W'(orow_n) + ADDR_W'(kr_n)) * ADDR_W'(DATA_Y)
                          + ADDR_W'(ocol_n) + ADDR_W'(kc_n);
            weight_addr_n = 5'(kr_n) * 5'(WEIGHT_Y) + 5'(kc_n);
            tap_first_n   = (kr_n == '0) && (kc_n == '0);
            tap_last_n    = (kr_n == KR_LAST) && (kc_n == KC_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kr   <= '0;
            kc   <= '0;
            orow <= '0;
            ocol <= '0;
        end else begin
            kr   <= kr_n;
            kc   <= kc_n;
            orow <= orow_n;
            ocol <= ocol_n;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy        <= 1'b0;
            tap_valid   <= 1'b0;
            data_addr   <= '0;
            weight_addr <= '0;
            tap_first   <= 1'b0;
            tap_last    <= 1'b0;
            result_wr   <= 1'b0;
            out_row     <= '0;
            out_col     <= '0;
            conv_done   <= 1'b0;
        end else begin
            busy        <= busy_n;
            tap_valid   <= tap_valid_n;
            data_addr   <= data_addr_n;
            weight_addr <= weight_addr_n;
            tap_first   <= tap_first_n;
            tap_last    <= tap_last_n;
            result_wr   <= result_wr_n;
            out_row     <= out_row_n;
            out_col     <= out_col_n;
            conv_done   <= conv_done_n;
        end
    end

`ifdef CONV_PERF_CNT_EN
    // Counts RUN, DRAIN and DONE cycles; the total stays visible in IDLE until the next start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_count <= '0;
        end else if (start) begin
            cycle_count <= '0;
        end else if (state != IDLE) begin
            cycle_count <= cycle_count + 32'd1;
        end
    end
`endif

endmodule
